// File: rtl/sigma_delta_final_pkg.sv
// Shared constants for the MASH 1-1-1 sigma-delta block: output coding,
// output/internal widths and the fraction-width derivation.
package sigma_delta_final_pkg;

    // Offset-binary coding: sd_out = y + SD_OFFSET, y in -3..+4
    localparam int SD_OFFSET = 3;
    localparam int SD_OUT_W  = 3;
    // Signed width of the combined MASH output before offsetting
    localparam int Y_W       = 4;

    // Fraction width is half the control-word width
    function automatic int frac_width(input int bitwidth);
        return bitwidth / 2;
    endfunction

endpackage

// File: rtl/mash111_core.sv
// Three cascaded first-order accumulators with the MASH 1-1-1 carry
// recombination network; advances only when en is high.
module mash111_core
    import sigma_delta_final_pkg::*;
#(
    parameter int F = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [F-1:0]        frac,
    output logic [SD_OUT_W-1:0] y_out
);

    logic [F-1:0] acc1, acc2, acc3;
    logic         c2_d, c3_d, c3_dd;
    logic [F:0]   sum1, sum2, sum3;
    logic         c1, c2, c3;
    logic signed [Y_W-1:0] y_p0;

    // Zero-extend a single carry bit into the signed combining width
    function automatic logic signed [Y_W-1:0] c_ext(input logic c);
        return {{(Y_W-1){1'b0}}, c};
    endfunction

    // Map signed y (-3..+4) onto the offset-binary output code (0..7)
    function automatic logic [SD_OUT_W-1:0] to_offset(input logic signed [Y_W-1:0] y);
        logic signed [Y_W-1:0] t;
        t = y + Y_W'(SD_OFFSET);
        return t[SD_OUT_W-1:0];
    endfunction

    // Accumulator sums for this tick; each stage adds the previous stage's new value
    always_comb begin
        sum1 = {1'b0, acc1} + {1'b0, frac};
        sum2 = {1'b0, acc2} + {1'b0, sum1[F-1:0]};
        sum3 = {1'b0, acc3} + {1'b0, sum2[F-1:0]};
        c1   = sum1[F];
        c2   = sum2[F];
        c3   = sum3[F];
        y_p0 = c_ext(c1)
             + (c_ext(c2) - c_ext(c2_d))
             + (c_ext(c3) - (c_ext(c3_d) <<< 1) + c_ext(c3_dd));
    end

    // Modulator state and registered output; reset wins over a coincident enable
    always_ff @(posedge clk) begin
        if (reset) begin
            acc1  <= '0;
            acc2  <= '0;
            acc3  <= '0;
            c2_d  <= 1'b0;
            c3_d  <= 1'b0;
            c3_dd <= 1'b0;
            y_out <= SD_OUT_W'(SD_OFFSET);
        end else if (en) begin
            acc1  <= sum1[F-1:0];
            acc2  <= sum2[F-1:0];
            acc3  <= sum3[F-1:0];
            c2_d  <= c2;
            c3_dd <= c3_d;
            c3_d  <= c3;
            y_out <= to_offset(y_p0);
        end
    end

endmodule

// File: rtl/sigma_delta_final_top.sv
// Sigma-delta top: divides clk by FSIG to produce the modulator tick and
// feeds the fractional half of kin into the MASH 1-1-1 core.
module sigma_delta_final_top
    import sigma_delta_final_pkg::*;
#(
    parameter int FSIG     = 1000,
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [BITWIDTH-1:0] kin,
    output logic [SD_OUT_W-1:0] sd_out
);

    localparam int F     = frac_width(BITWIDTH);
    localparam int CNT_W = (FSIG > 1) ? $clog2(FSIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FSIG - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic             unused_int;

    // The integer part of kin has no role in this block
    assign unused_int = ^kin[BITWIDTH-1:F];

    assign tick = (cnt == CNT_LAST);

    // Free-running 0..FSIG-1 divider; tick on the terminal count
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    mash111_core #(
        .F(F)
    ) u_core (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .frac  (kin[F-1:0]),
        .y_out (sd_out)
    );

endmodule

// File: tb/tb_sigma_delta_final_top.sv
// Directed bench: one instance at FSIG=1 for sequence/mean checks, one at
// FSIG=1000 for tick spacing and between-tick hold behaviour.
module tb_sigma_delta_final_top;

    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic [31:0] kin_a, kin_b;
    logic [2:0]  sd_a, sd_b;

    int n_chk = 0;
    int n_err = 0;

    // Expected per-tick output for f = 0x8000 after reset
    int pat [4] = '{3, 5, 2, 4};

    sigma_delta_final_top #(.FSIG(1), .BITWIDTH(32)) dut_a (
        .clk(clk), .reset(rst_a), .kin(kin_a), .sd_out(sd_a)
    );

    sigma_delta_final_top #(.FSIG(1000), .BITWIDTH(32)) dut_b (
        .clk(clk), .reset(rst_b), .kin(kin_b), .sd_out(sd_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Advance one edge and sample away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int sum;
        int prev;

        rst_a = 1'b1; kin_a = 32'hDEADBEEF;
        rst_b = 1'b1; kin_b = 32'h0000_8000;

        // Reset held with arbitrary kin: output parked at 3
        for (int i = 0; i < 5; i++) begin
            step();
            kin_a = $urandom;
            chk("rst_hold_a", sd_a, 3);
        end
        chk("rst_hold_b", sd_b, 3);

        // FSIG=1000: tick spacing and between-tick hold
        rst_b = 1'b0;
        bad = 0;
        prev = sd_b;
        for (int k = 1; k <= 5000; k++) begin
            step();
            if (sd_b != prev && (k % 1000) != 0) bad++;
            prev = sd_b;
            if (k == 2500) kin_b = 32'hFFFF_FFFF;
            if (k == 2900) kin_b = 32'h0000_8000;
            case (k)
                1000: chk("b_t1000", sd_b, 3);
                1999: chk("b_t1999", sd_b, 3);
                2000: chk("b_t2000", sd_b, 5);
                2999: chk("b_t2999", sd_b, 5);
                3000: chk("b_t3000", sd_b, 2);
                3999: chk("b_t3999", sd_b, 2);
                4000: chk("b_t4000", sd_b, 4);
                5000: chk("b_t5000", sd_b, 3);
                default: ;
            endcase
        end
        chk("b_hold_between_ticks", bad, 0);

        // FSIG=1, f=0: constant 3
        kin_a = 32'h1234_0000;
        step();
        rst_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sd_a != 3) bad++;
        end
        chk("a_f0_const", bad, 0);

        // FSIG=1, f=0x8000: 3,5,2,4 repeating
        rst_a = 1'b1; kin_a = 32'h0001_8000;
        step(); step();
        chk("a_rst_out", sd_a, 3);
        rst_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("a_half_%0d", i), sd_a, pat[i % 4]);
        end

        // Integer part swept every cycle: same sequence
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            kin_a = {16'($urandom), 16'h8000};
            step();
            if (sd_a != pat[i % 4]) bad++;
        end
        chk("a_sweep_int", bad, 0);

        // Mid-run reset restarts the pattern
        kin_a = 32'h0000_8000;
        for (int i = 0; i < 3; i++) step();
        rst_a = 1'b1;
        step();
        chk("a_midrst_out", sd_a, 3);
        step();
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("a_midrst_%0d", i), sd_a, pat[i]);
        end

        // kin = 0x082E6666: mean of sd-3 over 10000 ticks is 0.4 (sum ~4000)
        rst_a = 1'b1; kin_a = 32'h082E_6666;
        step();
        rst_a = 1'b0;
        sum = 0;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            sum += int'(sd_a) - 3;
            if (sd_a > 3'd7) bad++;
        end
        chk("a_mean_in_range", (sum >= 3990 && sum <= 4010) ? 1 : 0, 1);
        chk("a_out_range", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
